serdes_out_sdr: RTL

- Parametrised, single-clock, behavioural output serializer: the successor to the empty OSERDES simulation stub, with real shift behaviour.
- Accepts NCH parallel words of DATA_WIDTH bits through a valid/ready handshake and shifts them out one bit per clock.
- Double-buffered (holding register plus shift register), so back-to-back words stream without gaps; also provides tristate control and underrun reporting.
- Used in gateware and simulation wherever a vendor serializer primitive is unavailable or unsimulatable.

---
 rtl/serdes_out_sdr.sv | 84 ++++++++
 1 files changed

// File: rtl/serdes_out_sdr.sv
// serdes_out_sdr: double-buffered SDR output serializer with tristate control and underrun reporting.
module serdes_out_sdr #(
  parameter int   NCH           = 1,
  parameter int   DATA_WIDTH    = 8,
  parameter int   MSB_FIRST     = 0,
  parameter logic SRVAL         = 1'b0,
  parameter logic TRISTATE_IDLE = 1'b1
) (
  input  logic                      CLK,
  input  logic                      RST_N,
  input  logic [NCH*DATA_WIDTH-1:0] din,
  input  logic                      din_valid,
  output logic                      din_ready,
  input  logic                      oce,
  output logic [NCH-1:0]            oq,
  output logic                      tq,
  output logic                      busy,
  output logic                      word_start,
  output logic                      underrun
);
  localparam int CW = $clog2(DATA_WIDTH);
  typedef enum logic {IDLE, SHIFT} state_t;
  state_t                             state_q, state_d;
  logic [NCH-1:0][DATA_WIDTH-1:0]     hold_q, hold_d, sh_q, sh_d;
  logic                               hold_full_q, hold_full_d;
  logic [CW-1:0]                      cnt_q, cnt_d;
  logic                               word_start_q, underrun_q, underrun_d;
  logic                               last, load, accept;
  logic [NCH-1:0]                     out_bits;

  always_comb begin
    last        = cnt_q == CW'(DATA_WIDTH - 1);
    load        = oce && hold_full_q && (state_q == IDLE || last);
    accept      = din_valid && !hold_full_q;
    hold_d      = accept ? din : hold_q;
    hold_full_d = accept || (hold_full_q && !load);
    underrun_d  = state_q == SHIFT && oce && last && !hold_full_q;
    state_d     = state_q;
    cnt_d       = cnt_q;
    sh_d        = sh_q;
    if (load) begin
      sh_d    = hold_q;
      cnt_d   = '0;
      state_d = SHIFT;
    end else if (underrun_d) begin
      cnt_d   = '0;
      state_d = IDLE;
    end else if (state_q == SHIFT && oce) begin
      cnt_d = cnt_q + 1'b1;
      for (int k = 0; k < NCH; k++)
        sh_d[k] = MSB_FIRST != 0 ? {sh_q[k][DATA_WIDTH-2:0], 1'b0} : {1'b0, sh_q[k][DATA_WIDTH-1:1]};
    end
    for (int k = 0; k < NCH; k++)
      out_bits[k] = MSB_FIRST != 0 ? sh_q[k][DATA_WIDTH-1] : sh_q[k][0];
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state_q      <= IDLE;
      hold_q       <= '0;
      hold_full_q  <= 1'b0;
      sh_q         <= '0;
      cnt_q        <= '0;
      word_start_q <= 1'b0;
      underrun_q   <= 1'b0;
    end else begin
      state_q      <= state_d;
      hold_q       <= hold_d;
      hold_full_q  <= hold_full_d;
      sh_q         <= sh_d;
      cnt_q        <= cnt_d;
      word_start_q <= load;
      underrun_q   <= underrun_d;
    end
  end

  // Outputs decode registered state only, so oq/tq switch on the same edge as the state.
  assign busy       = state_q == SHIFT;
  assign oq         = busy ? out_bits : {NCH{SRVAL}};
  assign tq         = busy ? 1'b0 : TRISTATE_IDLE;
  assign din_ready  = !hold_full_q;
  assign word_start = word_start_q;
  assign underrun   = underrun_q;
endmodule
